// File: rtl/bitcrusher_mc_if.sv
// Bus bundle for the multi-channel bitcrusher: frame request, crush
// controls, packed sample buses and the done/busy status.
interface bitcrusher_mc_if #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int CRUSH_W  = 4,
  parameter int HOLD_W   = 4
);
  logic                        start;
  logic                        enable;
  logic                        round_mode;
  logic [CRUSH_W-1:0]          bits_to_crush;
  logic [HOLD_W-1:0]           hold_factor;
  logic [CHANNELS*WIDTH-1:0]   incoming_samples;
  logic [CHANNELS*WIDTH-1:0]   modified_samples;
  logic                        done;
  logic                        busy;

  // Requester side: issues frames and controls, observes results.
  modport master (
    output start, enable, round_mode, bits_to_crush, hold_factor, incoming_samples,
    input  modified_samples, done, busy
  );

  // Crusher side.
  modport slave (
    input  start, enable, round_mode, bits_to_crush, hold_factor, incoming_samples,
    output modified_samples, done, busy
  );
endinterface

// File: rtl/bitcrusher_mc.sv
// Multi-channel bitcrusher. A frame is latched on start, processed one
// channel per clock into a staging buffer, then published with a one-cycle
// done pulse. An optional hold counter repeats the last crushed frame to
// emulate a lower sample rate.
module bitcrusher_mc #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int CRUSH_W  = 4,
  parameter int HOLD_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  bitcrusher_mc_if.slave    bus
);

  localparam int KW   = $clog2(WIDTH + 1);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, PROCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q;
  logic               en_q;
  logic               rnd_q;
  logic               use_held_q;
  logic [KW-1:0]      k_q;
  logic [HOLD_W-1:0]  hold_cnt_q;

  logic [WIDTH-1:0]   frame_q   [CHANNELS];
  logic [WIDTH-1:0]   staging_q [CHANNELS];
  logic [WIDTH-1:0]   held_q    [CHANNELS];
  logic [WIDTH-1:0]   out_q     [CHANNELS];

  logic               accept;
  logic               last_step;
  logic [31:0]        btc_w;
  logic [KW-1:0]      k_clamped;
  logic [WIDTH-1:0]   cur_val;

  // Round (optional) and clear the k LSBs; a positive overflow from the
  // rounding offset saturates to the largest value with k LSBs cleared.
  function automatic logic [WIDTH-1:0] crush(input logic [WIDTH-1:0] x,
                                             input logic [KW-1:0]    k,
                                             input logic             rnd);
    logic signed [WIDTH:0] s, t, mask, half, maxp;
    mask = {(WIDTH+1){1'b1}} << k;
    half = '0;
    if (k != '0) half = (WIDTH+1)'(1) << (k - 1'b1);
    s    = $signed({x[WIDTH-1], x}) + (rnd ? half : '0);
    t    = s & mask;
    maxp = $signed({2'b00, {(WIDTH-1){1'b1}}});
    if (t > maxp) t = maxp & mask;
    return t[WIDTH-1:0];
  endfunction

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_step = (state_q == PROCESS) && (ch_q == LAST_CH);
  assign btc_w     = 32'(bus.bits_to_crush);
  assign k_clamped = (btc_w > 32'(WIDTH - 1)) ? KW'(WIDTH - 1) : KW'(btc_w);

  // Value produced for the channel currently being processed.
  always_comb begin
    cur_val = frame_q[ch_q];
    if (use_held_q)  cur_val = held_q[ch_q];
    else if (en_q)   cur_val = crush(frame_q[ch_q], k_q, rnd_q);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PROCESS;
      PROCESS: if (ch_q == LAST_CH) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame-level controls: latched settings, channel counter, hold counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      ch_q       <= '0;
      en_q       <= 1'b0;
      rnd_q      <= 1'b0;
      use_held_q <= 1'b0;
      k_q        <= '0;
      hold_cnt_q <= '0;
    end else if (accept) begin
      ch_q       <= '0;
      en_q       <= bus.enable;
      rnd_q      <= bus.round_mode;
      k_q        <= k_clamped;
      use_held_q <= bus.enable && (hold_cnt_q != '0);
      if (!bus.enable)                      hold_cnt_q <= '0;
      else if (hold_cnt_q >= bus.hold_factor) hold_cnt_q <= '0;
      else                                  hold_cnt_q <= hold_cnt_q + 1'b1;
    end else if (state_q == PROCESS) begin
      ch_q <= last_step ? '0 : ch_q + 1'b1;
    end
  end

  // Per-channel sample storage: latched input, staging, held and output.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset) begin
        frame_q[c]   <= '0;
        staging_q[c] <= '0;
        held_q[c]    <= '0;
        out_q[c]     <= '0;
      end else begin
        if (accept) frame_q[c] <= bus.incoming_samples[c*WIDTH +: WIDTH];
        if ((state_q == PROCESS) && (ch_q == CH_W'(c))) begin
          staging_q[c] <= cur_val;
          if (!en_q)           held_q[c] <= '0;
          else if (!use_held_q) held_q[c] <= cur_val;
        end
        // The last channel bypasses staging so the full frame is visible
        // in the done cycle.
        if (last_step) out_q[c] <= (c == CHANNELS - 1) ? cur_val : staging_q[c];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pack
      assign bus.modified_samples[gi*WIDTH +: WIDTH] = out_q[gi];
    end
  endgenerate

  assign bus.done = (state_q == DONE);
  assign bus.busy = (state_q != IDLE);

endmodule
